// File: rtl/sr_mem_arbiter.sv
// ---------------------------------------------------------------------------
// sr_mem_arbiter
//   Shares one slow backing-memory port between two requesters. Port 0 is the
//   instruction-fetch side (read only). Port 1 is the loader/debug side (read
//   or write). Single-cycle request strobes are captured into pending bits.
//   Requests are arbitrated round-robin and issued one at a time. The winner
//   gets a one-cycle data-ready pulse when its transaction completes.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   m0_req/m0_addr        port 0 request strobe and word address
//   m0_rdata/m0_drdy      port 0 read data and completion pulse
//   m1_req/m1_we/m1_addr/m1_wdata
//                         port 1 request strobe, write enable, address, data
//   m1_rdata/m1_drdy      port 1 read data and completion pulse (also for writes)
//   mem_req/mem_we/mem_addr/mem_wdata
//                         memory request level (held until mem_ack) and payload
//   mem_rdata/mem_ack     memory read data and completion pulse
//   err                   sticky timeout flag
//
// Configuration
//   SR_ARB_TIMEOUT_EN     when defined, a transaction is aborted if mem_ack
//                         does not arrive within TIMEOUT WAIT cycles. The
//                         winner then completes with rdata=0 and err is set
//                         until reset. When undefined, err is tied 0 and WAIT
//                         lasts until mem_ack arrives.
// ---------------------------------------------------------------------------
module sr_mem_arbiter #(
  parameter int unsigned AW      = 30,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  // port 0: instruction fetch
  input  logic          m0_req,
  input  logic [AW-1:0] m0_addr,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_drdy,
  // port 1: loader / debug
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_drdy,
  // shared memory
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } stateT;

  stateT         state;

  // Captured requests.
  logic          pend0;
  logic          pend1;
  logic [AW-1:0] addr0Q;
  logic [AW-1:0] addr1Q;
  logic          we1Q;
  logic [DW-1:0] wdata1Q;

  // Round-robin bookkeeping: grant is the port currently being served.
  logic          lastGrant;
  logic          grant;

  // Combinational arbitration terms.
  logic          take0;
  logic          take1;
  logic          eff0;
  logic          eff1;
  logic          pick;
  logic          startIssue;
  logic [AW-1:0] pickAddr;
  logic          pickWe;
  logic [DW-1:0] pickWdata;
  logic          timeoutHit;

  // Capture qualification and winner selection.
  // A strobe is taken when its port is not pending, or when the port is in
  // its completion cycle (drdy high), where a fresh strobe must not be lost.
  // The effective pending view drops the port that is completing this cycle
  // and adds any strobe being taken. That lets DONE chain straight into the
  // next ISSUE, and lets IDLE issue one cycle after the strobe.
  always_comb begin
    take0      = 1'b0;
    take1      = 1'b0;
    eff0       = 1'b0;
    eff1       = 1'b0;
    pick       = 1'b0;
    startIssue = 1'b0;
    pickAddr   = '0;
    pickWe     = 1'b0;
    pickWdata  = '0;

    take0 = m0_req & (~pend0 | m0_drdy);
    take1 = m1_req & (~pend1 | m1_drdy);
    eff0  = (pend0 & ~m0_drdy) | take0;
    eff1  = (pend1 & ~m1_drdy) | take1;

    if (eff0 && eff1) begin
      pick = ~lastGrant;
    end else if (eff1) begin
      pick = 1'b1;
    end

    startIssue = (eff0 | eff1) & ((state == IDLE) | (state == DONE));

    // Use the strobed fields when the capture happens in the same cycle.
    if (pick) begin
      pickAddr  = take1 ? m1_addr  : addr1Q;
      pickWe    = take1 ? m1_we    : we1Q;
      pickWdata = take1 ? m1_wdata : wdata1Q;
    end else begin
      pickAddr  = take0 ? m0_addr : addr0Q;
    end
  end

`ifdef SR_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] waitCnt;

  // Abort on the last allowed WAIT cycle if the memory still has not acked.
  assign timeoutHit = (state == WAIT) && !mem_ack &&
                      (waitCnt == CntW'(TIMEOUT - 1));

  // WAIT-cycle counter, restarted for every new transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waitCnt <= '0;
    end else if (startIssue) begin
      waitCnt <= '0;
    end else if ((state == WAIT) && !mem_ack) begin
      waitCnt <= waitCnt + CntW'(1);
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (timeoutHit) begin
      err <= 1'b1;
    end
  end
`else
  logic unusedTimeout;

  assign timeoutHit    = 1'b0;
  assign err           = 1'b0;
  assign unusedTimeout = (TIMEOUT != 0);
`endif

  // Arbiter FSM, capture registers and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pend0     <= 1'b0;
      pend1     <= 1'b0;
      addr0Q    <= '0;
      addr1Q    <= '0;
      we1Q      <= 1'b0;
      wdata1Q   <= '0;
      lastGrant <= 1'b1;
      grant     <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
      m0_drdy   <= 1'b0;
      m1_drdy   <= 1'b0;
    end else begin
      m0_drdy <= 1'b0;
      m1_drdy <= 1'b0;

      if (take0) begin
        pend0  <= 1'b1;
        addr0Q <= m0_addr;
      end
      if (take1) begin
        pend1   <= 1'b1;
        addr1Q  <= m1_addr;
        we1Q    <= m1_we;
        wdata1Q <= m1_wdata;
      end

      unique case (state)
        IDLE: begin
        end

        ISSUE, WAIT: begin
          if (mem_ack) begin
            state   <= DONE;
            mem_req <= 1'b0;
            if (grant) begin
              m1_drdy <= 1'b1;
              // A write completes without touching the read-data register.
              if (!mem_we) begin
                m1_rdata <= mem_rdata;
              end
            end else begin
              m0_drdy  <= 1'b1;
              m0_rdata <= mem_rdata;
            end
          end else if (timeoutHit) begin
            state   <= DONE;
            mem_req <= 1'b0;
            if (grant) begin
              m1_drdy  <= 1'b1;
              m1_rdata <= '0;
            end else begin
              m0_drdy  <= 1'b1;
              m0_rdata <= '0;
            end
          end else begin
            state <= WAIT;
          end
        end

        DONE: begin
          state <= IDLE;
          // Release the served port unless it re-strobed this cycle.
          if (grant) begin
            if (!take1) begin
              pend1 <= 1'b0;
            end
          end else begin
            if (!take0) begin
              pend0 <= 1'b0;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase

      // Start the next transaction. This overrides the IDLE/DONE next state.
      if (startIssue) begin
        state     <= ISSUE;
        grant     <= pick;
        lastGrant <= pick;
        mem_req   <= 1'b1;
        mem_we    <= pickWe;
        mem_addr  <= pickAddr;
        mem_wdata <= pickWdata;
      end
    end
  end

endmodule
